pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction cache (direct-mapped, 2-way or fully associative).
- Owns the program counter, drives PC to the cache, and samples HitWrite/Data_Cache.
- Freezes on a miss until the cache controller signals refill complete, then replays the access and issues registered instructions to decode.
- Also handles branch redirects and downstream stalls, and keeps fetch/stall counters.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes
CNT_W, 20, width of saturating performance counters

Ports:
CLK  in  1  system clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
HitWrite  in  1  cache hit for current PC (combinational from cache, same cycle)
Data_Cache  in  32  instruction word from cache, valid when HitWrite=1
Refill_Done  in  1  one-cycle pulse from cache controller: line for held PC written
Redirect_Valid  in  1  branch/jump redirect request
Redirect_PC  in  32  redirect target
ID_Stall  in  1  decode cannot accept; hold fetch
PC  out  32  registered fetch address to cache
IF_Instruction  out  32  registered fetched instruction
IF_PC  out  32  address of IF_Instruction
IF_Valid  out  1  IF_Instruction/IF_PC valid this cycle
Fetch_Busy  out  1  high in MISS or REPLAY
CNT_FETCH  out  CNT_W  instructions delivered (IF_Valid count)
CNT_STALL  out  CNT_W  cycles spent in MISS state

Behaviour:
- Reset (RESET=1 at edge): PC=RESET_PC, IF_Instruction=0, IF_PC=0, IF_Valid=0, Fetch_Busy=0, counters=0, redirect-pending cleared, state=RUN. Reset has priority over all inputs, including mid-MISS.
- FSM states: RUN, MISS, REPLAY.
- RUN, ID_Stall=1: PC, IF_* held; IF_Valid keeps its value; no counter change. Redirect is still accepted: PC<=Redirect_PC, IF_Valid<=0.
- RUN, ID_Stall=0, Redirect_Valid=1: PC<=Redirect_PC, IF_Valid<=0. The current cache result is discarded regardless of HitWrite, and no miss is taken.
- RUN, ID_Stall=0, Redirect_Valid=0, HitWrite=1: IF_Instruction<=Data_Cache, IF_PC<=PC, IF_Valid<=1, PC<=PC+PC_STEP (32-bit wrap, 32'hFFFFFFFC+4=0), CNT_FETCH++. Latency is 1 cycle from PC to IF_Instruction.
- RUN, ID_Stall=0, Redirect_Valid=0, HitWrite=0: go to MISS, PC held, IF_Valid<=0.
- MISS: PC held, IF_Valid=0, CNT_STALL++ each cycle. Redirect_Valid latches Redirect_PC into the pending register; a later redirect overwrites the earlier one. Refill_Done moves the FSM to REPLAY, or to RUN with PC<=pending target if a redirect is pending (pending is then cleared). A redirect arriving in the same cycle as Refill_Done counts as pending.
- REPLAY: one access at the held PC. If HitWrite=1, deliver as in RUN and go to RUN. If HitWrite=0, return to MISS. Redirect in REPLAY takes priority over delivery: PC<=target, go to RUN. ID_Stall in REPLAY holds in REPLAY.
- Fetch_Busy=1 exactly when state is MISS or REPLAY.
- Counters saturate at all-ones; they never wrap.
- Data_Cache is ignored whenever HitWrite=0.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: adds output Misalign (1 bit, reset 0). A redirect with Redirect_PC[1:0]!=0 sets Misalign sticky until reset, and the target is used with bits [1:0] forced to 0.
- Undefined: no Misalign port, and Redirect_PC is loaded verbatim.

Test Plan:
- Reset then hit stream: RESET 2 cycles, HitWrite=1, Data_Cache=PC^32'hA5A50000 -> PC 0,4,8,12; IF_PC lags by one cycle; CNT_FETCH=4 after 4 cycles.
- Miss/refill: HitWrite=0 at PC=16, Refill_Done pulse after 3 cycles, HitWrite=1 in REPLAY -> Fetch_Busy high for 4 cycles, CNT_STALL=3, IF_PC=16 delivered once, then PC=20.
- Redirect during miss: miss at PC=8, Redirect_PC=32'h40 in the 2nd MISS cycle, then Refill_Done -> no delivery of PC 8; next PC=32'h40, no REPLAY state.
- Redirect vs hit in RUN: HitWrite=1 and Redirect_Valid=1 with target 32'h100 at PC=4 -> IF_Valid=0, PC=32'h100, CNT_FETCH unchanged.
- ID_Stall and wrap: PC=32'hFFFFFFFC with ID_Stall=1 for 2 cycles -> PC held; release with hit -> IF_PC=32'hFFFFFFFC, PC=0.
- Reset mid-MISS and saturation: RESET in MISS -> state RUN, PC=RESET_PC, counters 0. Force CNT_STALL to all-ones -> stays at 20'hFFFFF.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end placed directly ahead of the I-cache.
// Owns the PC and presents it to the cache. A hit is sampled in the same cycle
// and registered toward decode. A miss freezes fetch until the refill pulse
// arrives, then the access is replayed. Also handles branch redirects, decode
// stalls and saturating fetch/stall counters.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds a sticky Misalign flag and
// forces redirect targets to word alignment.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned CNT_W    = 20
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             HitWrite,
   input  logic [31:0]      Data_Cache,
   input  logic             Refill_Done,
   input  logic             Redirect_Valid,
   input  logic [31:0]      Redirect_PC,
   input  logic             ID_Stall,
   output logic [31:0]      PC,
   output logic [31:0]      IF_Instruction,
   output logic [31:0]      IF_PC,
   output logic             IF_Valid,
   output logic             Fetch_Busy,
   output logic [CNT_W-1:0] CNT_FETCH,
   output logic [CNT_W-1:0] CNT_STALL
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic             Misalign
`endif
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StMiss   = 2'd1,
      StReplay = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [31:0]      PcInc  = 32'(PC_STEP);

   state_e      r_state;
   state_e      w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;
   logic        r_if_valid;
   logic        r_pend_valid;
   logic [31:0] r_pend_pc;
   logic [CNT_W-1:0] r_cnt_fetch;
   logic [CNT_W-1:0] r_cnt_stall;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_if_instr_nxt;
   logic [31:0] w_if_pc_nxt;
   logic        w_if_valid_nxt;
   logic        w_pend_valid_nxt;
   logic [31:0] w_pend_pc_nxt;
   logic        w_inc_fetch;
   logic        w_inc_stall;
   logic [31:0] w_redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        r_misalign;

   // Target is always word-aligned; low bits only feed the sticky flag.
   assign w_redir_pc = {Redirect_PC[31:2], 2'b00};

   // Sticky misalignment flag, set by any redirect with nonzero low bits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_misalign <= 1'b0;
      end else if (Redirect_Valid && (Redirect_PC[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end

   assign Misalign = r_misalign;
`else
   assign w_redir_pc = Redirect_PC;
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath next values; hold everything unless a case says otherwise.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_if_instr_nxt   = r_if_instr;
      w_if_pc_nxt      = r_if_pc;
      w_if_valid_nxt   = r_if_valid;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_pc_nxt    = r_pend_pc;
      w_inc_fetch      = 1'b0;
      w_inc_stall      = 1'b0;

      unique case (r_state)
         StRun: begin
            if (Redirect_Valid) begin
               // Redirect wins over both a hit and a decode stall.
               w_pc_nxt       = w_redir_pc;
               w_if_valid_nxt = 1'b0;
            end else if (!ID_Stall) begin
               if (HitWrite) begin
                  w_if_instr_nxt = Data_Cache;
                  w_if_pc_nxt    = r_pc;
                  w_if_valid_nxt = 1'b1;
                  w_pc_nxt       = r_pc + PcInc;
                  w_inc_fetch    = 1'b1;
               end else begin
                  w_state_nxt    = StMiss;
                  w_if_valid_nxt = 1'b0;
               end
            end
         end

         StMiss: begin
            w_if_valid_nxt = 1'b0;
            w_inc_stall    = 1'b1;
            if (Refill_Done) begin
               if (Redirect_Valid) begin
                  // Same-cycle redirect is the newest pending target.
                  w_pc_nxt         = w_redir_pc;
                  w_state_nxt      = StRun;
                  w_pend_valid_nxt = 1'b0;
               end else if (r_pend_valid) begin
                  w_pc_nxt         = r_pend_pc;
                  w_state_nxt      = StRun;
                  w_pend_valid_nxt = 1'b0;
               end else begin
                  w_state_nxt = StReplay;
               end
            end else if (Redirect_Valid) begin
               w_pend_valid_nxt = 1'b1;
               w_pend_pc_nxt    = w_redir_pc;
            end
         end

         StReplay: begin
            if (Redirect_Valid) begin
               w_pc_nxt       = w_redir_pc;
               w_if_valid_nxt = 1'b0;
               w_state_nxt    = StRun;
            end else if (!ID_Stall) begin
               if (HitWrite) begin
                  w_if_instr_nxt = Data_Cache;
                  w_if_pc_nxt    = r_pc;
                  w_if_valid_nxt = 1'b1;
                  w_pc_nxt       = r_pc + PcInc;
                  w_inc_fetch    = 1'b1;
                  w_state_nxt    = StRun;
               end else begin
                  w_if_valid_nxt = 1'b0;
                  w_state_nxt    = StMiss;
               end
            end
         end

         default: begin
            w_state_nxt = StRun;
         end
      endcase
   end

   // PC, decode-side outputs and pending-redirect storage.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pc         <= RESET_PC;
         r_if_instr   <= 32'd0;
         r_if_pc      <= 32'd0;
         r_if_valid   <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_pc    <= 32'd0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_if_instr   <= w_if_instr_nxt;
         r_if_pc      <= w_if_pc_nxt;
         r_if_valid   <= w_if_valid_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_pc    <= w_pend_pc_nxt;
      end
   end

   // Saturating performance counters; they stick at all-ones.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt_fetch <= '0;
         r_cnt_stall <= '0;
      end else begin
         if (w_inc_fetch && (r_cnt_fetch != CntMax)) begin
            r_cnt_fetch <= r_cnt_fetch + CntOne;
         end
         if (w_inc_stall && (r_cnt_stall != CntMax)) begin
            r_cnt_stall <= r_cnt_stall + CntOne;
         end
      end
   end

   assign PC             = r_pc;
   assign IF_Instruction = r_if_instr;
   assign IF_PC          = r_if_pc;
   assign IF_Valid       = r_if_valid;
   assign Fetch_Busy     = (r_state != StRun);
   assign CNT_FETCH      = r_cnt_fetch;
   assign CNT_STALL      = r_cnt_stall;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit. A second instance with
// 3-bit counters shares all stimulus so counter saturation is reachable quickly.
module tb_pc_fetch_unit;

   localparam logic [31:0] Key = 32'hA5A50000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        HitWrite = 1'b0;
   logic [31:0] Data_Cache;
   logic        Refill_Done = 1'b0;
   logic        Redirect_Valid = 1'b0;
   logic [31:0] Redirect_PC = 32'd0;
   logic        ID_Stall = 1'b0;

   logic [31:0] PC, IF_Instruction, IF_PC;
   logic        IF_Valid, Fetch_Busy;
   logic [19:0] CNT_FETCH, CNT_STALL;

   logic [31:0] PC_s, IF_Instruction_s, IF_PC_s;
   logic        IF_Valid_s, Fetch_Busy_s;
   logic [2:0]  CNT_FETCH_s, CNT_STALL_s;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        Misalign, Misalign_s;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] m_pc;
   int unsigned m_fetch;
   int unsigned m_stall;

   always #5 CLK = ~CLK;

   // Cache model: word is a function of the presented address; junk on a miss.
   assign Data_Cache = HitWrite ? (PC ^ Key) : 32'hDEADBEEF;

   pc_fetch_unit u_dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .HitWrite       (HitWrite),
      .Data_Cache     (Data_Cache),
      .Refill_Done    (Refill_Done),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .ID_Stall       (ID_Stall),
      .PC             (PC),
      .IF_Instruction (IF_Instruction),
      .IF_PC          (IF_PC),
      .IF_Valid       (IF_Valid),
      .Fetch_Busy     (Fetch_Busy),
      .CNT_FETCH      (CNT_FETCH),
      .CNT_STALL      (CNT_STALL)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .Misalign       (Misalign)
`endif
   );

   pc_fetch_unit #(.CNT_W(3)) u_dut_sat (
      .CLK            (CLK),
      .RESET          (RESET),
      .HitWrite       (HitWrite),
      .Data_Cache     (Data_Cache),
      .Refill_Done    (Refill_Done),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .ID_Stall       (ID_Stall),
      .PC             (PC_s),
      .IF_Instruction (IF_Instruction_s),
      .IF_PC          (IF_PC_s),
      .IF_Valid       (IF_Valid_s),
      .Fetch_Busy     (Fetch_Busy_s),
      .CNT_FETCH      (CNT_FETCH_s),
      .CNT_STALL      (CNT_STALL_s)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .Misalign       (Misalign_s)
`endif
   );

   function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
      int unsigned mx;
      mx = (32'd1 << w) - 32'd1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic exp_busy, input logic exp_valid);
      chk({tag, "_pc"}, PC, m_pc);
      chk({tag, "_busy"}, {31'd0, Fetch_Busy}, {31'd0, exp_busy});
      chk({tag, "_valid"}, {31'd0, IF_Valid}, {31'd0, exp_valid});
      chk({tag, "_cnt_fetch"}, {12'd0, CNT_FETCH}, sat(m_fetch, 20));
      chk({tag, "_cnt_stall"}, {12'd0, CNT_STALL}, sat(m_stall, 20));
      chk({tag, "_sat_fetch"}, {29'd0, CNT_FETCH_s}, sat(m_fetch, 3));
      chk({tag, "_sat_stall"}, {29'd0, CNT_STALL_s}, sat(m_stall, 3));
   endtask

   // One clock of stimulus; a fresh delivery is popped from the scoreboard.
   task automatic step(input logic hit, input logic stall, input logic rv,
                       input logic [31:0] rpc, input logic refill);
      exp_t e;
      @(negedge CLK);
      RESET          = 1'b0;
      HitWrite       = hit;
      ID_Stall       = stall;
      Redirect_Valid = rv;
      Redirect_PC    = rpc;
      Refill_Done    = refill;
      @(posedge CLK);
      #1;
      if (IF_Valid && !stall) begin
         n_tests++;
         assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed IF_PC %h expected no delivery", IF_PC);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_if_pc", IF_PC, e.pc);
            chk("sb_if_instr", IF_Instruction, e.instr);
         end
      end
   endtask

   task automatic hit(input string tag);
      exp_t e;
      e.pc    = m_pc;
      e.instr = m_pc ^ Key;
      sb_q.push_back(e);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      m_pc = m_pc + 32'd4;
      m_fetch++;
      chk_all(tag, 1'b0, 1'b1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RESET          = 1'b1;
      HitWrite       = 1'b0;
      ID_Stall       = 1'b0;
      Redirect_Valid = 1'b0;
      Refill_Done    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      m_pc    = 32'd0;
      m_fetch = 0;
      m_stall = 0;
      chk_all(tag, 1'b0, 1'b0);
      chk({tag, "_if_pc"}, IF_PC, 32'd0);
      chk({tag, "_if_instr"}, IF_Instruction, 32'd0);
   endtask

   initial begin
      m_pc    = 32'd0;
      m_fetch = 0;
      m_stall = 0;

      do_reset("reset");

      // Sequential hit stream 0,4,8,12.
      repeat (4) hit("hit_stream");

      // Miss at 16, refill pulse in the third MISS cycle, replay hits.
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("miss_enter", 1'b1, 1'b0);
      repeat (2) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         m_stall++;
         chk_all("miss_wait", 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      m_stall++;
      chk_all("refill", 1'b1, 1'b0);
      hit("replay_hit");

      // Redirect beats a hit in RUN.
      step(1'b1, 1'b0, 1'b1, 32'h4, 1'b0);
      m_pc = 32'h4;
      chk_all("redir_to4", 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      m_pc = 32'h100;
      chk_all("redir_vs_hit", 1'b0, 1'b0);

      // Redirect during a miss at 8 replaces the replay.
      step(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
      m_pc = 32'h8;
      chk_all("redir_to8", 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("miss8_enter", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      m_stall++;
      step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      m_stall++;
      chk_all("miss_redir", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      m_stall++;
      m_pc = 32'h40;
      chk_all("refill_pending", 1'b0, 1'b0);
      hit("after_redir");

      // Later redirect overwrites; one arriving with the refill pulse is taken.
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("miss44_enter", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
      m_stall++;
      step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
      m_stall++;
      m_pc = 32'h300;
      chk_all("refill_redir_same", 1'b0, 1'b0);

      // Decode stall holds everything; wrap past the top of the address space.
      step(1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0);
      m_pc = 32'hFFFFFFF8;
      chk_all("redir_top", 1'b0, 1'b0);
      hit("pre_wrap");
      repeat (2) begin
         step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
         chk_all("stall_hold", 1'b0, 1'b1);
         chk("stall_if_pc", IF_PC, 32'hFFFFFFF8);
      end
      hit("wrap");
      chk("wrap_pc_zero", PC, 32'd0);

      // Redirect is still accepted under a decode stall.
      step(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
      m_pc = 32'h80;
      chk_all("stall_redir", 1'b0, 1'b0);

      // REPLAY: stall holds, miss returns to MISS, redirect exits to RUN.
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("miss80_enter", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      m_stall++;
      chk_all("replay_enter", 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      chk_all("replay_stall", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("replay_miss", 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      m_stall++;
      chk_all("replay_again", 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0);
      m_pc = 32'hC0;
      chk_all("replay_redir", 1'b0, 1'b0);

      // Long miss drives the narrow stall counter into saturation.
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk_all("long_miss_enter", 1'b1, 1'b0);
      repeat (10) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         m_stall++;
         chk_all("long_miss", 1'b1, 1'b0);
      end
      chk("sat_stall_ones", {29'd0, CNT_STALL_s}, 32'd7);

      // Reset while in MISS.
      do_reset("reset_mid_miss");
      hit("post_reset");

      chk("sb_empty", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
